// File: rtl/mem_port_arbiter.sv
// Shares one external memory port between instruction fetch and load/store traffic.
// Data wins arbitration unless fetch has been passed over STARVE_LIMIT times in a row.
module mem_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned TIMEOUT_CYC  = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ack,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wmask,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic        mem_valid,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        timeout_err
);

    localparam int unsigned StarveW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam int unsigned WaitW   = (TIMEOUT_CYC < 1) ? 1 : $clog2(TIMEOUT_CYC + 1);
    localparam logic [StarveW-1:0] StarveMax = StarveW'(STARVE_LIMIT);
    localparam logic [WaitW-1:0]   WaitLast  = WaitW'(TIMEOUT_CYC - 1);
    localparam bit                 TimeoutEn = (TIMEOUT_CYC != 0);

    typedef enum logic [2:0] {
        StIdle,
        StBusyD,
        StBusyI,
        StRespD,
        StRespI
    } state_e;

    state_e             state_q, state_d;
    logic [StarveW-1:0] starve_cnt_q, starve_cnt_d;
    logic [WaitW-1:0]   wait_cnt_q, wait_cnt_d;
    logic               timeout_err_q, timeout_err_d;
    logic               mem_we_q, mem_we_d;
    logic [31:0]        mem_addr_q, mem_addr_d;
    logic [31:0]        mem_wdata_q, mem_wdata_d;
    logic [3:0]         mem_wmask_q, mem_wmask_d;
    logic [31:0]        d_rdata_q, d_rdata_d;
    logic [31:0]        i_rdata_q, i_rdata_d;

    logic starved;
    logic d_wins;
    logic timeout_hit;

    always_comb begin
        starved     = i_req && (starve_cnt_q == StarveMax);
        d_wins      = d_req && !starved;
        timeout_hit = TimeoutEn && (wait_cnt_q == WaitLast) && !mem_ready;
    end

    always_comb begin
        state_d       = state_q;
        starve_cnt_d  = starve_cnt_q;
        wait_cnt_d    = wait_cnt_q;
        timeout_err_d = timeout_err_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        mem_wmask_d   = mem_wmask_q;
        d_rdata_d     = d_rdata_q;
        i_rdata_d     = i_rdata_q;

        unique case (state_q)
            StIdle: begin
                if (!i_req) begin
                    starve_cnt_d = '0;
                end
                if (d_wins) begin
                    state_d     = StBusyD;
                    wait_cnt_d  = '0;
                    mem_addr_d  = d_addr;
                    mem_we_d    = d_we;
                    mem_wdata_d = d_wdata;
                    mem_wmask_d = d_we ? d_wmask : 4'b0000;
                    // Only count data grants that actually made fetch wait.
                    if (i_req && (starve_cnt_q != StarveMax)) begin
                        starve_cnt_d = starve_cnt_q + 1'b1;
                    end
                end else if (i_req) begin
                    state_d      = StBusyI;
                    wait_cnt_d   = '0;
                    mem_addr_d   = i_addr;
                    mem_we_d     = 1'b0;
                    mem_wdata_d  = '0;
                    mem_wmask_d  = 4'b0000;
                    starve_cnt_d = '0;
                end
            end

            StBusyD: begin
                wait_cnt_d = wait_cnt_q + 1'b1;
                // Stores leave d_rdata alone; it only ever carries load data.
                if (mem_ready) begin
                    state_d = StRespD;
                    if (!mem_we_q) begin
                        d_rdata_d = mem_rdata;
                    end
                end else if (timeout_hit) begin
                    state_d       = StRespD;
                    timeout_err_d = 1'b1;
                    if (!mem_we_q) begin
                        d_rdata_d = '0;
                    end
                end
            end

            StBusyI: begin
                wait_cnt_d = wait_cnt_q + 1'b1;
                if (mem_ready) begin
                    state_d   = StRespI;
                    i_rdata_d = mem_rdata;
                end else if (timeout_hit) begin
                    state_d       = StRespI;
                    timeout_err_d = 1'b1;
                    i_rdata_d     = '0;
                end
            end

            StRespD, StRespI: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            starve_cnt_q  <= '0;
            wait_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            mem_wmask_q   <= '0;
            d_rdata_q     <= '0;
            i_rdata_q     <= '0;
        end else begin
            state_q       <= state_d;
            starve_cnt_q  <= starve_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            timeout_err_q <= timeout_err_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            mem_wmask_q   <= mem_wmask_d;
            d_rdata_q     <= d_rdata_d;
            i_rdata_q     <= i_rdata_d;
        end
    end

    // Handshake outputs decode straight from state so reset removes them immediately.
    assign mem_valid   = (state_q == StBusyD) || (state_q == StBusyI);
    assign d_ack       = (state_q == StRespD);
    assign i_ack       = (state_q == StRespI);
    assign busy        = (state_q != StIdle);
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign mem_wmask   = mem_wmask_q;
    assign d_rdata     = d_rdata_q;
    assign i_rdata     = i_rdata_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus a randomized run against a
// transaction-level reference model of the arbitration and handshake rules.
module tb_mem_port_arbiter;

    localparam int STARVE  = 4;
    localparam int TIMEOUT = 8;

    logic        clk;
    logic        reset;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_ack;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wmask;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        mem_valid;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        busy;
    logic        timeout_err;

    int total = 0;
    int bad   = 0;

    mem_port_arbiter #(
        .STARVE_LIMIT(STARVE),
        .TIMEOUT_CYC (TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .i_req      (i_req),
        .i_addr     (i_addr),
        .i_rdata    (i_rdata),
        .i_ack      (i_ack),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_wmask    (d_wmask),
        .d_rdata    (d_rdata),
        .d_ack      (d_ack),
        .mem_valid  (mem_valid),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wmask  (mem_wmask),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish want finish before time limit");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_wmask = '0;
        mem_ready = 1'b0; mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({mem_valid, mem_we, busy, d_ack, i_ack, timeout_err} !== 6'b0) begin
            bad++;
            $display("FAIL reset_ctrl: got %b want %b",
                     {mem_valid, mem_we, busy, d_ack, i_ack, timeout_err}, 6'b0);
        end
        total++;
        if ({mem_addr, mem_wdata, mem_wmask} !== 68'h0) begin
            bad++;
            $display("FAIL reset_mem: got %h want 0", {mem_addr, mem_wdata, mem_wmask});
        end
        total++;
        if ({d_rdata, i_rdata} !== 64'h0) begin
            bad++;
            $display("FAIL reset_rdata: got %h want 0", {d_rdata, i_rdata});
        end
        reset = 1'b1;
        tick();
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle: got busy=%b want 0", busy);
        end
    endtask

    task automatic test_load();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100; d_wdata = 32'hFFFF_FFFF; d_wmask = 4'hF;
        total++;
        if (mem_valid !== 1'b0) begin
            bad++;
            $display("FAIL load_c0: got mem_valid=%b want 0", mem_valid);
        end
        tick();
        total++;
        if ({mem_valid, mem_we, mem_addr, mem_wmask} !== {1'b1, 1'b0, 32'h100, 4'h0}) begin
            bad++;
            $display("FAIL load_c1: got %b %b %h %h want 1 0 00000100 0",
                     mem_valid, mem_we, mem_addr, mem_wmask);
        end
        mem_ready = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        tick();
        mem_ready = 1'b0; d_req = 1'b0;
        total++;
        if ({mem_valid, d_ack, i_ack} !== 3'b010 || d_rdata !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL load_c2: got valid/dack/iack=%b rdata=%h want 010 deadbeef",
                     {mem_valid, d_ack, i_ack}, d_rdata);
        end
        tick();
        total++;
        if ({d_ack, busy} !== 2'b00 || d_rdata !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL load_c3: got ack/busy=%b rdata=%h want 00 deadbeef",
                     {d_ack, busy}, d_rdata);
        end
    endtask

    task automatic test_store();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h204; d_wdata = 32'h1234_5678; d_wmask = 4'b0011;
        mem_rdata = 32'h5A5A_5A5A;
        for (int k = 1; k <= 4; k++) begin
            tick();
            total++;
            if ({mem_valid, mem_we, mem_addr, mem_wdata, mem_wmask, d_ack} !==
                {1'b1, 1'b1, 32'h204, 32'h1234_5678, 4'b0011, 1'b0}) begin
                bad++;
                $display("FAIL store_hold%0d: got %b %b %h %h %b ack=%b want 1 1 204 12345678 0011 0",
                         k, mem_valid, mem_we, mem_addr, mem_wdata, mem_wmask, d_ack);
            end
            if (k == 4) mem_ready = 1'b1;
        end
        tick();
        mem_ready = 1'b0; d_req = 1'b0;
        total++;
        if ({mem_valid, d_ack} !== 2'b01 || d_rdata !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL store_ack: got valid/ack=%b rdata=%h want 01 deadbeef",
                     {mem_valid, d_ack}, d_rdata);
        end
        tick();
        total++;
        if (d_ack !== 1'b0) begin
            bad++;
            $display("FAIL store_single_ack: got %b want 0", d_ack);
        end
    endtask

    task automatic test_contention();
        int n;
        bit want_i;
        logic [31:0] rd;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000; i_req = 1'b1; i_addr = 32'h1000;
        mem_ready = 1'b0;
        for (int g = 0; g < 10; g++) begin
            n = 0;
            while (mem_valid !== 1'b1 && n < 6) begin
                tick();
                n++;
            end
            want_i = ((g % (STARVE + 1)) == STARVE);
            total++;
            if (n != ((g == 0) ? 1 : 2)) begin
                bad++;
                $display("FAIL contention_gap%0d: got %0d cycles want %0d", g, n, (g == 0) ? 1 : 2);
            end
            total++;
            if (mem_addr !== (want_i ? 32'h1000 : 32'h2000)) begin
                bad++;
                $display("FAIL contention_grant%0d: got addr %h want %h", g, mem_addr,
                         want_i ? 32'h1000 : 32'h2000);
            end
            rd = 32'hA5A5_0000 | 32'(g);
            mem_ready = 1'b1; mem_rdata = rd;
            tick();
            mem_ready = 1'b0;
            total++;
            if ({d_ack, i_ack} !== (want_i ? 2'b01 : 2'b10)) begin
                bad++;
                $display("FAIL contention_ack%0d: got d/i=%b want %b", g, {d_ack, i_ack},
                         want_i ? 2'b01 : 2'b10);
            end
            total++;
            if ((want_i ? i_rdata : d_rdata) !== rd) begin
                bad++;
                $display("FAIL contention_rdata%0d: got %h want %h", g,
                         want_i ? i_rdata : d_rdata, rd);
            end
        end
        d_req = 1'b0; i_req = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_held_request();
        i_req = 1'b1; i_addr = 32'h3000;
        tick();
        total++;
        if ({mem_valid, mem_addr} !== {1'b1, 32'h3000}) begin
            bad++;
            $display("FAIL held_first: got %b %h want 1 00003000", mem_valid, mem_addr);
        end
        mem_ready = 1'b1; mem_rdata = 32'h1111_2222;
        tick();
        mem_ready = 1'b0;
        total++;
        if (i_ack !== 1'b1 || i_rdata !== 32'h1111_2222) begin
            bad++;
            $display("FAIL held_ack1: got ack=%b rdata=%h want 1 11112222", i_ack, i_rdata);
        end
        tick();
        total++;
        if ({mem_valid, busy, i_ack} !== 3'b000) begin
            bad++;
            $display("FAIL held_idle: got %b want 000", {mem_valid, busy, i_ack});
        end
        tick();
        total++;
        if ({mem_valid, mem_addr} !== {1'b1, 32'h3000}) begin
            bad++;
            $display("FAIL held_second: got %b %h want 1 00003000", mem_valid, mem_addr);
        end
        mem_ready = 1'b1; mem_rdata = 32'h3333_4444;
        tick();
        mem_ready = 1'b0; i_req = 1'b0;
        total++;
        if (i_ack !== 1'b1 || i_rdata !== 32'h3333_4444) begin
            bad++;
            $display("FAIL held_ack2: got ack=%b rdata=%h want 1 33334444", i_ack, i_rdata);
        end
        tick();
        total++;
        if ({i_ack, busy} !== 2'b00) begin
            bad++;
            $display("FAIL held_done: got %b want 00", {i_ack, busy});
        end
    endtask

    // Reference model tracks the access in flight as a record, not as RTL state.
    task automatic test_random();
        bit m_busy, m_resp, m_who_i, m_we, have_load, quiet;
        int m_starve, m_lat;
        logic [31:0] m_addr, m_wdata, m_ret, last_load;
        logic [3:0] m_wmask;
        m_busy = 0; m_resp = 0; m_who_i = 0; m_we = 0; have_load = 0;
        m_starve = 0; m_lat = 0; m_addr = '0; m_wdata = '0; m_ret = '0; m_wmask = '0;
        last_load = '0;
        d_req = 1'b0; i_req = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            quiet = !d_req && !i_req && !m_busy && !m_resp;
            if (c >= 800 && quiet) break;
            if (c < 800 && !d_req && $urandom_range(0, 3) != 0) begin
                d_req = 1'b1; d_we = 1'($urandom_range(0, 1));
                d_addr = $urandom & 32'h0000_FFFC; d_wdata = $urandom; d_wmask = 4'($urandom);
            end
            if (c < 800 && !i_req && $urandom_range(0, 3) != 0) begin
                i_req = 1'b1; i_addr = $urandom & 32'h0000_FFFC;
            end
            if (m_busy) begin
                mem_ready = (m_lat == 0);
                if (m_lat > 0) m_lat--;
            end else begin
                mem_ready = 1'($urandom_range(0, 1));
            end
            mem_rdata = $urandom;
            tick();

            if (m_resp) begin
                m_resp = 0;
            end else if (m_busy) begin
                if (mem_ready) begin
                    m_busy = 0; m_resp = 1; m_ret = mem_rdata;
                end
            end else begin
                if (!i_req) m_starve = 0;
                if (d_req && !(i_req && m_starve == STARVE)) begin
                    m_busy = 1; m_who_i = 0; m_addr = d_addr; m_we = d_we; m_wdata = d_wdata;
                    m_wmask = d_we ? d_wmask : 4'b0000;
                    if (i_req && m_starve < STARVE) m_starve++;
                    m_lat = $urandom_range(0, 4);
                end else if (i_req) begin
                    m_busy = 1; m_who_i = 1; m_addr = i_addr; m_we = 0; m_wmask = 4'b0000;
                    m_starve = 0;
                    m_lat = $urandom_range(0, 4);
                end
            end

            total++;
            if ({mem_valid, busy, d_ack, i_ack} !==
                {m_busy, m_busy | m_resp, m_resp & !m_who_i, m_resp & m_who_i}) begin
                bad++;
                $display("FAIL rand_ctrl c%0d: got valid/busy/dack/iack=%b want %b", c,
                         {mem_valid, busy, d_ack, i_ack},
                         {m_busy, m_busy | m_resp, m_resp & !m_who_i, m_resp & m_who_i});
            end
            if (m_busy) begin
                total++;
                if ({mem_addr, mem_we, mem_wmask} !== {m_addr, m_we, m_wmask} ||
                    (m_we && mem_wdata !== m_wdata)) begin
                    bad++;
                    $display("FAIL rand_port c%0d: got %h %b %b %h want %h %b %b %h", c,
                             mem_addr, mem_we, mem_wmask, mem_wdata,
                             m_addr, m_we, m_wmask, m_wdata);
                end
            end
            if (m_resp && m_who_i) begin
                total++;
                if (i_rdata !== m_ret) begin
                    bad++;
                    $display("FAIL rand_irdata c%0d: got %h want %h", c, i_rdata, m_ret);
                end
            end
            if (m_resp && !m_who_i && !m_we) begin
                total++;
                if (d_rdata !== m_ret) begin
                    bad++;
                    $display("FAIL rand_drdata c%0d: got %h want %h", c, d_rdata, m_ret);
                end
                last_load = m_ret; have_load = 1;
            end
            if (m_resp && !m_who_i && m_we && have_load) begin
                total++;
                if (d_rdata !== last_load) begin
                    bad++;
                    $display("FAIL rand_store_rdata c%0d: got %h want %h", c, d_rdata, last_load);
                end
            end
            total++;
            if (timeout_err !== 1'b0) begin
                bad++;
                $display("FAIL rand_timeout_err c%0d: got %b want 0", c, timeout_err);
            end
            if (m_resp) begin
                if (m_who_i) i_req = 1'b0;
                else d_req = 1'b0;
            end
        end
        mem_ready = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        i_req = 1'b1; i_addr = 32'h5000; mem_ready = 1'b0;
        for (int k = 1; k <= TIMEOUT; k++) begin
            tick();
            total++;
            if ({mem_valid, i_ack, timeout_err} !== 3'b100) begin
                bad++;
                $display("FAIL timeout_wait%0d: got %b want 100", k, {mem_valid, i_ack, timeout_err});
            end
        end
        tick();
        i_req = 1'b0;
        total++;
        if ({i_ack, timeout_err} !== 2'b11 || i_rdata !== 32'h0) begin
            bad++;
            $display("FAIL timeout_ack: got ack/err=%b rdata=%h want 11 00000000",
                     {i_ack, timeout_err}, i_rdata);
        end
        tick();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h600;
        tick();
        mem_ready = 1'b1; mem_rdata = 32'h7777_8888;
        tick();
        mem_ready = 1'b0; d_req = 1'b0;
        total++;
        if ({d_ack, timeout_err} !== 2'b11 || d_rdata !== 32'h7777_8888) begin
            bad++;
            $display("FAIL timeout_sticky: got ack/err=%b rdata=%h want 11 77778888",
                     {d_ack, timeout_err}, d_rdata);
        end
        tick();
    endtask

    task automatic test_reset_abort();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h700;
        tick();
        total++;
        if (mem_valid !== 1'b1) begin
            bad++;
            $display("FAIL abort_busy: got mem_valid=%b want 1", mem_valid);
        end
        #2 reset = 1'b0;
        #1;
        total++;
        if ({mem_valid, busy, timeout_err} !== 3'b000) begin
            bad++;
            $display("FAIL abort_immediate: got %b want 000", {mem_valid, busy, timeout_err});
        end
        d_req = 1'b0; mem_ready = 1'b1;
        tick();
        tick();
        reset = 1'b1; mem_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            total++;
            if ({d_ack, mem_valid} !== 2'b00) begin
                bad++;
                $display("FAIL abort_no_ack%0d: got %b want 00", k, {d_ack, mem_valid});
            end
        end
        i_req = 1'b1; i_addr = 32'h8000;
        tick();
        total++;
        if ({mem_valid, mem_addr} !== {1'b1, 32'h8000}) begin
            bad++;
            $display("FAIL abort_fetch_port: got %b %h want 1 00008000", mem_valid, mem_addr);
        end
        mem_ready = 1'b1; mem_rdata = 32'h9999_AAAA;
        tick();
        mem_ready = 1'b0; i_req = 1'b0;
        total++;
        if (i_ack !== 1'b1 || i_rdata !== 32'h9999_AAAA) begin
            bad++;
            $display("FAIL abort_fetch_ack: got ack=%b rdata=%h want 1 9999aaaa", i_ack, i_rdata);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_load();
        test_store();
        test_contention();
        test_held_request();
        test_random();
        test_timeout();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
